// File: rtl/pixel_compositor.sv
// Pixel compositor: arbitrates wall/player layers onto the sprite-sheet ROM and drives VGA RGB.
// Optional chroma keying of player pixels is enabled with the COMPOSITOR_COLOR_KEY_EN macro.
`timescale 1ns/1ps

module pixel_compositor #(
  parameter int                ADDR_W      = 17,
  parameter int                RGB_W       = 12,
  parameter int                FADE_FRAMES = 8,
  parameter logic [RGB_W-1:0]  BG_COLOR    = '0,
  parameter logic [RGB_W-1:0]  KEY_COLOR   = RGB_W'(12'h0F0)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [3:0]        state,
  input  logic              valid_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              wall_obj,
  input  logic [ADDR_W-1:0] wall_addr,
  input  logic              player_obj,
  input  logic [ADDR_W-1:0] player_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]  rom_data,
  output logic [RGB_W-1:0]  vga_rgb,
  output logic              hsync,
  output logic              vsync
);

  localparam int CNT_W_RAW = $clog2(FADE_FRAMES + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FADE_FRAMES);

  typedef enum logic [1:0] {SEL_NONE, SEL_WALL, SEL_PLAYER} sel_e;
  typedef enum logic {FADE_SHOW, FADE_BLANK} fade_e;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  sel_e              sel_q, sel_d;
  logic              valid_s0_q, valid_s0_d;
  logic              hsync_s0_q, hsync_s0_d;
  logic              vsync_s0_q, vsync_s0_d;
  logic [RGB_W-1:0]  vga_rgb_q, vga_rgb_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  fade_e             fade_q, fade_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        prev_state_q;

  logic              vs_fall;
  logic              state_chg;
  logic [CNT_W-1:0]  cnt_inc;
  logic              unused_inputs;

  // Coordinates are carried for future layers; keep them visibly consumed.
`ifdef COMPOSITOR_COLOR_KEY_EN
  assign unused_inputs = ^{h_cnt, v_cnt};
`else
  assign unused_inputs = ^{h_cnt, v_cnt, KEY_COLOR};
`endif

  // Stage 0: layer arbitration (player wins) and sync capture.
  always_comb begin
    rom_addr_d = rom_addr_q;
    sel_d      = sel_q;
    valid_s0_d = valid_s0_q;
    hsync_s0_d = hsync_s0_q;
    vsync_s0_d = vsync_s0_q;
    if (pix_en) begin
      valid_s0_d = valid_in;
      hsync_s0_d = hsync_in;
      vsync_s0_d = vsync_in;
      if (player_obj) begin
        rom_addr_d = player_addr;
        sel_d      = SEL_PLAYER;
      end else if (wall_obj) begin
        rom_addr_d = wall_addr;
        sel_d      = SEL_WALL;
      end else begin
        rom_addr_d = '0;
        sel_d      = SEL_NONE;
      end
    end
  end

  // Stage 1: ROM data has arrived, pick the final colour.
  always_comb begin
    vga_rgb_d = vga_rgb_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    if (pix_en) begin
      hsync_d = hsync_s0_q;
      vsync_d = vsync_s0_q;
      if (!valid_s0_q || fade_q == FADE_BLANK) begin
        vga_rgb_d = '0;
      end else if (sel_q == SEL_NONE) begin
        vga_rgb_d = BG_COLOR;
      end else begin
        vga_rgb_d = rom_data;
`ifdef COMPOSITOR_COLOR_KEY_EN
        if (sel_q == SEL_PLAYER && rom_data == KEY_COLOR) begin
          vga_rgb_d = BG_COLOR;
        end
`endif
      end
    end
  end

  // Fade FSM: a state change restarts the blank window, vsync falls count frames.
  always_comb begin
    fade_d    = fade_q;
    cnt_d     = cnt_q;
    vs_fall   = pix_en && vsync_s0_q && !vsync_in;
    state_chg = (state != prev_state_q);
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    case (fade_q)
      FADE_SHOW: begin
        if (state_chg && FADE_FRAMES != 0) begin
          fade_d = FADE_BLANK;
          cnt_d  = '0;
        end
      end
      FADE_BLANK: begin
        if (state_chg) begin
          cnt_d = '0;
        end else if (vs_fall) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            fade_d = FADE_SHOW;
          end
        end
      end
      default: begin
        fade_d = FADE_SHOW;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    prev_state_q <= state;
    if (!rst_n) begin
      rom_addr_q <= '0;
      sel_q      <= SEL_NONE;
      valid_s0_q <= 1'b0;
      hsync_s0_q <= 1'b1;
      vsync_s0_q <= 1'b1;
      vga_rgb_q  <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      fade_q     <= FADE_SHOW;
      cnt_q      <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      sel_q      <= sel_d;
      valid_s0_q <= valid_s0_d;
      hsync_s0_q <= hsync_s0_d;
      vsync_s0_q <= vsync_s0_d;
      vga_rgb_q  <= vga_rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      fade_q     <= fade_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign vga_rgb  = vga_rgb_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Scoreboard bench for pixel_compositor: stimulus pushes expected pixels, a monitor pops them
// two pix_en ticks later (rom_addr one tick later).
`timescale 1ns/1ps

module tb_pixel_compositor;

   localparam logic [11:0] BG = 12'h123;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_en;
   logic [1:0]  pixDiv = 2'd0;
   logic [3:0]  state = 4'd0;
   logic        valid_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
   logic [9:0]  h_cnt = '0, v_cnt = '0;
   logic        wall_obj = 1'b0, player_obj = 1'b0;
   logic [16:0] wall_addr = '0, player_addr = '0;
   logic [16:0] rom_addr;
   logic [11:0] rom_data;
   logic [11:0] vga_rgb;
   logic        hsync, vsync;

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      string       name;
   } exp_t;

   exp_t        expQ[$];
   logic [16:0] addrQ[$];
   int          checks = 0;
   int          errors = 0;
   int          monTick = 0;

   // model state for the fade window, seen from the stimulus side
   logic [3:0]  lastState = 4'd0;
   logic        lastVs = 1'b1;
   logic        blank = 1'b0;
   int          falls = 0;

   pixel_compositor #(
      .ADDR_W(17), .RGB_W(12), .FADE_FRAMES(2), .BG_COLOR(BG), .KEY_COLOR(12'h0F0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .state(state),
      .valid_in(valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .h_cnt(h_cnt), .v_cnt(v_cnt),
      .wall_obj(wall_obj), .wall_addr(wall_addr),
      .player_obj(player_obj), .player_addr(player_addr),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .vga_rgb(vga_rgb), .hsync(hsync), .vsync(vsync)
   );

   always #5 clk = ~clk;

   // pixel strobe: one clk in four
   always @(posedge clk) pixDiv <= pixDiv + 2'd1;
   assign pix_en = (pixDiv == 2'd3);

   // sprite-sheet ROM contents the bench knows by hand
   function automatic logic [11:0] romModel(input logic [16:0] a);
      case (a)
         17'h00123: romModel = 12'hF00;
         17'h09600: romModel = 12'h00F;
         17'h00200: romModel = 12'h0F0;
         17'h09700: romModel = 12'h0F0;
         17'h1F000: romModel = 12'hFFF;
         default:   romModel = 12'h777;
      endcase
   endfunction

   always_comb rom_data = romModel(rom_addr);

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // drive one pixel just ahead of the next pix_en edge and queue its expectations
   task automatic applyStimulus(input logic v, input logic hs, input logic vs,
                                input logic wo, input logic [16:0] wa,
                                input logic po, input logic [16:0] pa,
                                input logic [3:0] st, input logic [11:0] rgb,
                                input logic [9:0] hc, input logic [9:0] vc,
                                input string name);
      exp_t e;
      do begin
         @(posedge clk);
         #2;
      end while (!pix_en);
      rst_n       = 1'b1;
      valid_in    = v;
      hsync_in    = hs;
      vsync_in    = vs;
      wall_obj    = wo;
      wall_addr   = wa;
      player_obj  = po;
      player_addr = pa;
      state       = st;
      h_cnt       = hc;
      v_cnt       = vc;
      if (st != lastState) begin
         blank = 1'b1;
         falls = 0;
      end else if (blank && lastVs && !vs) begin
         falls++;
         if (falls == 2) blank = 1'b0;
      end
      lastState = st;
      lastVs    = vs;
      e.rgb  = blank ? 12'h000 : rgb;
      e.hs   = hs;
      e.vs   = vs;
      e.name = name;
      expQ.push_back(e);
      addrQ.push_back(po ? pa : (wo ? wa : 17'h0));
   endtask

   // scaled timing: 16 ticks per line (10 active, hsync low at 12..13), 6 lines, vsync low on line 4
   task automatic runFrame(input logic [3:0] stA, input logic [3:0] stB, input int swLine);
      logic v, hs, vs, po, wo;
      logic [11:0] rgb;
      for (int ln = 0; ln < 6; ln++) begin
         for (int px = 0; px < 16; px++) begin
            v   = (px < 10) && (ln < 4);
            hs  = !(px == 12 || px == 13);
            vs  = (ln != 4);
            po  = (px == 3) || (px == 4);
            wo  = (px % 4) >= 2;
            rgb = !v ? 12'h000 : (po ? 12'hF00 : (wo ? 12'h00F : BG));
            applyStimulus(v, hs, vs, wo, 17'h09600, po, 17'h00123,
                          (ln < swLine) ? stA : stB, rgb, 10'(px), 10'(ln), "frame");
         end
      end
   endtask

   // monitor: rom_addr follows one tick after stimulus, pixels and syncs two ticks after
   always @(posedge clk) begin
      if (!rst_n) begin
         monTick = 0;
      end else if (pix_en) begin
         #1;
         if (monTick == 0) begin
            checkOutput("first_tick_rgb", 32'(vga_rgb), 32'h0);
            checkOutput("first_tick_hsync", 32'(hsync), 32'h1);
         end
         if (addrQ.size() != 0) begin
            logic [16:0] ea;
            ea = addrQ.pop_front();
            checkOutput("rom_addr", 32'(rom_addr), 32'(ea));
         end
         if (monTick >= 1 && expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput({e.name, "_rgb"}, 32'(vga_rgb), 32'(e.rgb));
            checkOutput({e.name, "_hsync"}, 32'(hsync), 32'(e.hs));
            checkOutput({e.name, "_vsync"}, 32'(vsync), 32'(e.vs));
         end
         monTick++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] r;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         r = $urandom;
         state = r[3:0]; valid_in = r[4]; hsync_in = r[5]; vsync_in = r[6];
         wall_obj = r[7]; player_obj = r[8];
         r = $urandom; wall_addr = r[16:0];
         r = $urandom; player_addr = r[16:0];
         @(posedge clk);
         #1;
         checkOutput("reset_rgb", 32'(vga_rgb), 32'h0);
         checkOutput("reset_hsync", 32'(hsync), 32'h1);
         checkOutput("reset_vsync", 32'(vsync), 32'h1);
         checkOutput("reset_rom_addr", 32'(rom_addr), 32'h0);
      end
      state = 4'd0; valid_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      wall_obj = 1'b0; player_obj = 1'b0;
      repeat (4) @(posedge clk);

      $display("[TB] sync alignment and fade sequence");
      runFrame(4'd0, 4'd0, 0);
      runFrame(4'd0, 4'd2, 2);
      runFrame(4'd2, 4'd3, 1);
      runFrame(4'd3, 4'd3, 0);
      runFrame(4'd3, 4'd3, 0);

      $display("[TB] directed pixels");
      applyStimulus(1, 1, 1, 1, 17'h09600, 1, 17'h00123, 4'd3, 12'hF00, 10'd0, 10'd0, "priority");
      applyStimulus(1, 1, 1, 1, 17'h09600, 0, 17'h00123, 4'd3, 12'h00F, 10'd1, 10'd0, "wall_only");
      applyStimulus(1, 1, 1, 0, 17'h09600, 0, 17'h00123, 4'd3, BG,      10'd2, 10'd0, "background");
      applyStimulus(0, 1, 1, 1, 17'h1F000, 0, 17'h00000, 4'd3, 12'h000, 10'd3, 10'd0, "invalid");
`ifdef COMPOSITOR_COLOR_KEY_EN
      applyStimulus(1, 1, 1, 0, 17'h00000, 1, 17'h00200, 4'd3, BG,      10'd4, 10'd0, "key_player");
`else
      applyStimulus(1, 1, 1, 0, 17'h00000, 1, 17'h00200, 4'd3, 12'h0F0, 10'd4, 10'd0, "key_player");
`endif
      applyStimulus(1, 1, 1, 1, 17'h09700, 0, 17'h00000, 4'd3, 12'h0F0, 10'd5, 10'd0, "key_wall");
      applyStimulus(1, 0, 1, 0, 17'h00000, 0, 17'h00000, 4'd3, BG,      10'd6, 10'd0, "hsync_low");
      applyStimulus(1, 1, 0, 1, 17'h09600, 0, 17'h00000, 4'd3, 12'h00F, 10'd7, 10'd0, "vsync_low");
      applyStimulus(1, 1, 1, 0, 17'h00000, 1, 17'h00123, 4'd3, 12'hF00, 10'd8, 10'd0, "player_only");

      for (int i = 0; i < 200 && (expQ.size() != 0 || addrQ.size() != 0); i++) @(posedge clk);
      #3;
      if (expQ.size() != 0 || addrQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size() + addrQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
